// File: rtl/exibe_pontuacao.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | exibe_pontuacao: shows a 0..100 score on three active-low 7-seg digits,  |
// | using a serial double-dabble converter and an optional count-up roll-in. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module exibe_pontuacao #(
    parameter int ANIM_DIV = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       carrega,
    input  logic [6:0] pontos,
    input  logic       animar,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic       ocupado,
    output logic       pronto
);

    localparam int              c_DIV_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(ANIM_DIV - 1);
    localparam logic [6:0]      c_MAX      = 7'd100;
    localparam logic [6:0]      c_BLANK    = 7'b1111111;

    typedef enum logic [1:0] {
        INICIAL  = 2'd0,
        CONVERTE = 2'd1,
        ESPERA   = 2'd2
    } estado_t;

    estado_t            r_estado, w_proximo;
    logic [6:0]         r_alvo, r_atual;
    logic [18:0]        r_sr;       // {bcd[11:0], binary[6:0]}
    logic [2:0]         r_iter;
    logic [c_DIV_W-1:0] r_div;
    logic [6:0]         r_hex0, r_hex1, r_hex2;
    logic               r_ocupado, r_pronto;

    logic               w_carga, w_fim_conv, w_tick;
    logic [6:0]         w_sat;
    logic [6:0]         w_inicio;
    logic [18:0]        w_aj, w_sr_prox;
    logic [3:0]         w_cent, w_dez, w_uni;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign w_sat    = (pontos > c_MAX) ? c_MAX : pontos;
    assign w_inicio = animar ? 7'd0 : w_sat;

    // One double-dabble step: add 3 to any BCD digit >= 5, then shift left.
    always_comb begin
        w_aj = r_sr;
        for (int i = 0; i < 3; i++) begin
            if (r_sr[7+4*i +: 4] >= 4'd5) begin
                w_aj[7+4*i +: 4] = r_sr[7+4*i +: 4] + 4'd3;
            end
        end
        w_sr_prox = w_aj << 1;
    end

    assign w_cent = w_sr_prox[18:15];
    assign w_dez  = w_sr_prox[14:11];
    assign w_uni  = w_sr_prox[10:7];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo  = r_estado;
        w_carga    = 1'b0;
        w_fim_conv = 1'b0;
        w_tick     = 1'b0;
        case (r_estado)
            INICIAL: begin
                if (carrega) begin
                    w_carga   = 1'b1;
                    w_proximo = CONVERTE;
                end
            end
            CONVERTE: begin
                if (r_iter == 3'd6) begin
                    w_fim_conv = 1'b1;
                    w_proximo  = (r_atual == r_alvo) ? INICIAL : ESPERA;
                end
            end
            ESPERA: begin
                if (r_div == c_DIV_LAST) begin
                    w_tick    = 1'b1;
                    w_proximo = CONVERTE;
                end
            end
            default: w_proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_alvo    <= '0;
            r_atual   <= '0;
            r_sr      <= '0;
            r_iter    <= '0;
            r_div     <= '0;
            r_hex0    <= 7'b1000000;
            r_hex1    <= c_BLANK;
            r_hex2    <= c_BLANK;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
        end else begin
            r_pronto  <= 1'b0;
            r_ocupado <= (w_proximo != INICIAL);
            if (w_carga) begin
                r_alvo  <= w_sat;
                r_atual <= w_inicio;
                r_sr    <= {12'd0, w_inicio};
                r_iter  <= '0;
            end else if (r_estado == CONVERTE) begin
                r_sr   <= w_sr_prox;
                r_iter <= r_iter + 3'd1;
                if (w_fim_conv) begin
                    // Blank leading zeros: hundreds only for 100, tens below 10.
                    r_hex0 <= f_seg(w_uni);
                    r_hex1 <= (w_cent == 4'd0 && w_dez == 4'd0) ? c_BLANK : f_seg(w_dez);
                    r_hex2 <= (w_cent == 4'd0) ? c_BLANK : f_seg(w_cent);
                    r_pronto <= (r_atual == r_alvo);
                    r_div    <= '0;
                end
            end else if (r_estado == ESPERA) begin
                if (w_tick) begin
                    r_atual <= r_atual + 7'd1;
                    r_sr    <= {12'd0, r_atual + 7'd1};
                    r_iter  <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
        end
    end

    assign hex0    = r_hex0;
    assign hex1    = r_hex1;
    assign hex2    = r_hex2;
    assign ocupado = r_ocupado;
    assign pronto  = r_pronto;

endmodule
`default_nettype wire

// File: doc/exibe_pontuacao.md
# exibe_pontuacao

Score display unit for the Sinfonia do Espectro game: it reads the 7-bit accumulated score produced by the scoring datapath and presents it as decimal digits on three active-low seven-segment displays. The value is converted to BCD with a sequential shift-add-3 (double-dabble) engine rather than a combinational divider. An optional count-up animation steps the shown value from 0 to the target so the end-of-game score "rolls in".

## Interface

Parameters:
- ANIM_DIV, 500000 — clock cycles between animation increments (10 ms at 50 MHz); must be ≥ 1.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- carrega  in  1  single-cycle request to load and display `pontos`.
- pontos  in  7  score from the scoring register, nominally 0..100.
- animar  in  1  sampled with `carrega`; 1 = count up from 0, 0 = show target directly.
- hex0  out  7  units digit, active-low, bit order gfedcba.
- hex1  out  7  tens digit, same encoding.
- hex2  out  7  hundreds digit, same encoding.
- ocupado  out  1  high while a load is in progress (states CONVERTE and ESPERA).
- pronto  out  1  one-cycle pulse when the final target value is on the displays.

## Operation

- Target register `alvo` (7 bits) and shown value `atual` (7 bits).
- On an accepted `carrega`:
  - `alvo <= min(pontos, 100)`; any `pontos` > 100 saturates to 100.
  - `atual <= 0` if `animar`, else `atual <= alvo`.
- FSM states:
  - INICIAL: idle, displays hold. On `carrega`, load as above and go to CONVERTE.
  - CONVERTE: 7 iterations of double-dabble on `atual`, one bit per cycle, producing a 12-bit BCD value (only 3 digits used; max 100). In the 7th cycle, write the display registers.
    - If `atual == alvo`: assert `pronto` and go to INICIAL.
    - Otherwise clear the divider and go to ESPERA.
  - ESPERA: divider counts ANIM_DIV cycles. On terminal count, `atual <= atual + 1` and return to CONVERTE.
- Digit encoding (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
- Leading-zero blanking:
  - hex2 blank unless the value is 100.
  - hex1 blank when the value is < 10.
  - hex0 always shows a digit.
- `carrega` while `ocupado` is ignored; the in-progress load completes unchanged.
- `carrega` in the same cycle that `pronto` asserts is ignored (the FSM is not yet in INICIAL).
- `alvo == 0` with `animar = 1`: a single conversion, then `pronto`; no ESPERA.
- `animar` is ignored outside an accepted `carrega`.

## Timing

- Reset values:
  - state INICIAL; `alvo = atual = 0`; divider = 0.
  - `hex0 = 1000000` (shows "0"); `hex1 = hex2 = 1111111`.
  - `ocupado = 0`; `pronto = 0`.
- Reset mid-operation: on the next edge, all registers take their reset values; no `pronto` is emitted.
- All outputs are registered; no combinational path from inputs to outputs.
- Direct load: `carrega` sampled at edge k.
  - `ocupado` = 1 from edge k through edge k+7.
  - CONVERTE occupies edges k+1..k+7; the display updates and `pronto` = 1 at edge k+7, for exactly one cycle.
  - Back in INICIAL at edge k+7, so a new `carrega` is accepted from edge k+8.
- Animated load: the n-th displayed value (n = 0..alvo) updates at edge k + 7 + n·(ANIM_DIV + 7).
  - `pronto` asserts with the n = alvo update.
  - `ocupado` is continuous until then.
- Displays change only at conversion completion, never mid-conversion.

## Test plan

- Reset then idle → hex0 = 1000000, hex1 = hex2 = 1111111, `ocupado = 0`, `pronto = 0`.
- `carrega` with `pontos = 57`, `animar = 0` → 7 cycles later hex1 = 0010010, hex0 = 1111000, hex2 blank; `pronto` high for 1 cycle.
- `pontos = 127`, `animar = 0` → displays "100": hex2 = 1111001, hex1 = hex0 = 1000000.
- ANIM_DIV = 3, `pontos = 12`, `animar = 1` → displays step through 0, 1, …, 12 every 10 cycles; `pronto` only after 12, at 7 + 12·10 = 127 cycles.
- Second `carrega` (`pontos = 99`) during an animation → ignored, final display is still 12; `pontos = 5` → hex1 blank, hex0 = 0010010.
- `reset` pulse mid-animation at value 6 → next cycle displays show "0", `ocupado = 0`, no `pronto`.
